// File: rtl/fpu_unpack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : fpu_unpack_pkg                                           |
// | Description: Shared constants for the FP operand unpacker: one-hot    |
// |              class bit indices and IEEE-754 field widths and biases.  |
// | Revision   : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package fpu_unpack_pkg;

  // One-hot class vector bit positions, ordered {snan, qnan, inf, norm, sub, zero}
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_QNAN = 4;
  localparam int CLS_SNAN = 5;
  localparam int CLS_W    = 6;

  typedef logic [CLS_W-1:0] cls_t;

  // Single precision
  localparam int SP_W    = 32;
  localparam int SP_EW   = 8;
  localparam int SP_SW   = SP_W - SP_EW - 1;
  localparam int SP_BIAS = 127;

  // Double precision
  localparam int DP_W    = 64;
  localparam int DP_EW   = 11;
  localparam int DP_SW   = DP_W - DP_EW - 1;
  localparam int DP_BIAS = 1023;

endpackage : fpu_unpack_pkg
`default_nettype wire

// File: rtl/fp_class_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fp_class_decode                                          |
// | Description: Combinational classifier for one operand. Turns the      |
// |              registered field flags into a one-hot class, the hidden  |
// |              significand bit and the output exponent.                 |
// |              FPU_UNPACK_DAZ_EN: when defined, subnormals decode as    |
// |              zero (exponent 0, hidden bit 0).                         |
// | Revision   : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fp_class_decode
  import fpu_unpack_pkg::*;
#(
  parameter int EW = 8
) (
  input  logic          exp_zero,
  input  logic          exp_ones,
  input  logic          frac_zero,
  input  logic          frac_msb,
  input  logic [EW-1:0] exp_field,
  output cls_t          cls,
  output logic          hidden,
  output logic [EW:0]   exp_out
);

  // Priority decode: exponent extremes first, everything else is normal
  always_comb begin
    cls     = '0;
    hidden  = 1'b1;
    exp_out = {1'b0, exp_field};
    if (exp_zero) begin
      hidden  = 1'b0;
      exp_out = '0;
      if (frac_zero) begin
        cls[CLS_ZERO] = 1'b1;
      end else begin
`ifdef FPU_UNPACK_DAZ_EN
        cls[CLS_ZERO] = 1'b1;
`else
        // Subnormals share the minimum normal exponent so the datapath can align them directly
        cls[CLS_SUB] = 1'b1;
        exp_out      = {{EW{1'b0}}, 1'b1};
`endif
      end
    end else if (exp_ones) begin
      if (frac_zero) begin
        cls[CLS_INF] = 1'b1;
      end else if (frac_msb) begin
        cls[CLS_QNAN] = 1'b1;
      end else begin
        cls[CLS_SNAN] = 1'b1;
      end
    end else begin
      cls[CLS_NORM] = 1'b1;
    end
  end

endmodule : fp_class_decode
`default_nettype wire

// File: rtl/fp_operand_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fp_operand_unpacker                                      |
// | Description: Two-stage stallable pipeline that splits a pair of       |
// |              packed IEEE-754 operands into sign/exponent/significand  |
// |              and a one-hot class, with valid/ready on both sides.     |
// |              FPU_UNPACK_DAZ_EN: when defined, subnormal inputs are    |
// |              delivered as signed zeros.                               |
// | Revision   : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fp_operand_unpacker
  import fpu_unpack_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign_a,
  output logic              out_sign_b,
  output logic [EW:0]       out_exp_a,
  output logic [EW:0]       out_exp_b,
  output logic [W-EW-1:0]   out_man_a,
  output logic [W-EW-1:0]   out_man_b,
  output logic [CLS_W-1:0]  out_cls_a,
  output logic [CLS_W-1:0]  out_cls_b,
  output logic              out_invalid
);

  localparam int SW = W - EW - 1;

  logic [W-1:0] op [2];
  assign op[0] = in_a;
  assign op[1] = in_b;

  // Stage 1: raw fields plus pre-computed field compares
  logic          s1_valid;
  logic          s1_sign [2];
  logic [EW-1:0] s1_exp  [2];
  logic [SW-1:0] s1_frac [2];
  logic          s1_ez [2], s1_eo [2], s1_fz [2], s1_fm [2];

  // Stage 2: decoded result, drives the outputs directly
  logic          s2_valid;
  logic          s2_sign [2];
  logic [EW:0]   s2_exp  [2];
  logic [SW:0]   s2_man  [2];
  cls_t          s2_cls  [2];
  logic          s2_invalid;

  // Decoder results for the pair sitting in stage 1
  cls_t          d_cls    [2];
  logic          d_hidden [2];
  logic [EW:0]   d_exp    [2];

  logic s1_en, s2_en;
  assign s2_en    = ~s2_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  for (genvar g = 0; g < 2; g++) begin : g_dec
    fp_class_decode #(.EW(EW)) u_dec (
      .exp_zero  (s1_ez[g]),
      .exp_ones  (s1_eo[g]),
      .frac_zero (s1_fz[g]),
      .frac_msb  (s1_fm[g]),
      .exp_field (s1_exp[g]),
      .cls       (d_cls[g]),
      .hidden    (d_hidden[g]),
      .exp_out   (d_exp[g])
    );
  end

  // Stage 1 capture: split fields and compare them against zero / all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1_sign[i] <= 1'b0;
        s1_exp[i]  <= '0;
        s1_frac[i] <= '0;
        s1_ez[i]   <= 1'b0;
        s1_eo[i]   <= 1'b0;
        s1_fz[i]   <= 1'b0;
        s1_fm[i]   <= 1'b0;
      end
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 2; i++) begin
          s1_sign[i] <= op[i][W-1];
          s1_exp[i]  <= op[i][W-2:SW];
          s1_frac[i] <= op[i][SW-1:0];
          s1_ez[i]   <= (op[i][W-2:SW] == '0);
          s1_eo[i]   <= (op[i][W-2:SW] == '1);
          s1_fz[i]   <= (op[i][SW-1:0] == '0);
          s1_fm[i]   <= op[i][SW-1];
        end
      end
    end
  end

  // Stage 2 capture: decoded class/exponent; a zero class also clears the fraction (DAZ)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid   <= 1'b0;
      s2_invalid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s2_sign[i] <= 1'b0;
        s2_exp[i]  <= '0;
        s2_man[i]  <= '0;
        s2_cls[i]  <= '0;
      end
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_invalid <= d_cls[0][CLS_SNAN] | d_cls[1][CLS_SNAN];
        for (int i = 0; i < 2; i++) begin
          s2_sign[i] <= s1_sign[i];
          s2_exp[i]  <= d_exp[i];
          s2_man[i]  <= {d_hidden[i], (d_cls[i][CLS_ZERO] ? {SW{1'b0}} : s1_frac[i])};
          s2_cls[i]  <= d_cls[i];
        end
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_invalid = s2_invalid;
  assign out_sign_a  = s2_sign[0];
  assign out_sign_b  = s2_sign[1];
  assign out_exp_a   = s2_exp[0];
  assign out_exp_b   = s2_exp[1];
  assign out_man_a   = s2_man[0];
  assign out_man_b   = s2_man[1];
  assign out_cls_a   = s2_cls[0];
  assign out_cls_b   = s2_cls[1];

endmodule : fp_operand_unpacker
`default_nettype wire

// File: tb/tb_fp_operand_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_fp_operand_unpacker                                   |
// | Description: Self-checking bench for fp_operand_unpacker. Random      |
// |              operand pairs and handshakes are scored against an IEEE  |
// |              reference model and a queue of in-flight pairs.          |
// |              FPU_UNPACK_DAZ_EN: bench model follows the same macro.   |
// | Revision   : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_fp_operand_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        out_sign_a, out_sign_b, out_invalid;
  logic [8:0]  out_exp_a, out_exp_b;
  logic [23:0] out_man_a, out_man_b;
  logic [5:0]  out_cls_a, out_cls_b;

  fp_operand_unpacker #(.W(32), .EW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_a(out_sign_a), .out_sign_b(out_sign_b),
    .out_exp_a(out_exp_a), .out_exp_b(out_exp_b),
    .out_man_a(out_man_a), .out_man_b(out_man_b),
    .out_cls_a(out_cls_a), .out_cls_b(out_cls_b),
    .out_invalid(out_invalid)
  );

  logic        dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
  logic [63:0] dp_in_a, dp_in_b;
  logic        dp_sign_a, dp_sign_b, dp_invalid;
  logic [11:0] dp_exp_a, dp_exp_b;
  logic [52:0] dp_man_a, dp_man_b;
  logic [5:0]  dp_cls_a, dp_cls_b;

  fp_operand_unpacker #(.W(64), .EW(11)) dut_dp (
    .clk(clk), .rst(rst),
    .in_valid(dp_in_valid), .in_ready(dp_in_ready), .in_a(dp_in_a), .in_b(dp_in_b),
    .out_valid(dp_out_valid), .out_ready(dp_out_ready),
    .out_sign_a(dp_sign_a), .out_sign_b(dp_sign_b),
    .out_exp_a(dp_exp_a), .out_exp_b(dp_exp_b),
    .out_man_a(dp_man_a), .out_man_b(dp_man_b),
    .out_cls_a(dp_cls_a), .out_cls_b(dp_cls_b),
    .out_invalid(dp_invalid)
  );

  typedef struct {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] man;
    logic [5:0]  cls;
  } op_t;

  typedef struct {
    op_t  a;
    op_t  b;
    logic inv;
    int   acc;
  } pair_t;

  pair_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // IEEE-754 single precision unpack from the field rules, using integer arithmetic
  function automatic op_t model(input logic [31:0] x);
    op_t m;
    int unsigned e, f;
    e = (x >> 23) & 32'hFF;
    f = x & 32'h7FFFFF;
    m.sign = x[31];
    if (e == 0 && f == 0) begin
      m.cls = 6'b000001; m.exp = 9'd0; m.man = 24'd0;
    end else if (e == 0) begin
`ifdef FPU_UNPACK_DAZ_EN
      m.cls = 6'b000001; m.exp = 9'd0; m.man = 24'd0;
`else
      m.cls = 6'b000010; m.exp = 9'd1; m.man = 24'(f);
`endif
    end else if (e < 255) begin
      m.cls = 6'b000100; m.exp = 9'(e); m.man = 24'(f + (1 << 23));
    end else begin
      m.exp = 9'd255;
      m.man = 24'(f + (1 << 23));
      if (f == 0)             m.cls = 6'b001000;
      else if (f >= (1 << 22)) m.cls = 6'b010000;
      else                    m.cls = 6'b100000;
    end
    return m;
  endfunction

  // Random operand biased toward every class
  function automatic logic [31:0] gen_op();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 6))
      0:       return {r[31], 31'd0};
      1:       return {r[31], 8'h00, r[22:0] | 23'd1};
      2:       return {r[31], e, r[22:0]};
      3:       return {r[31], 8'hFF, 23'd0};
      4:       return {r[31], 8'hFF, 1'b1, r[21:0]};
      5:       return {r[31], 8'hFF, 1'b0, r[21:0] | 22'd1};
      default: return r;
    endcase
  endfunction

  // Score one cycle: occupancy-based handshake expectations, then output data
  task automatic observe();
    pair_t p;
    logic  exp_ov;
    cyc++;
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    check("out_valid", out_valid, exp_ov);
    check("in_ready", in_ready, (q.size() < 2) || out_ready);
    if (out_valid && q.size() > 0) begin
      p = q[0];
      check("sign_a", out_sign_a, p.a.sign);
      check("exp_a",  out_exp_a,  p.a.exp);
      check("man_a",  out_man_a,  p.a.man);
      check("cls_a",  out_cls_a,  p.a.cls);
      check("sign_b", out_sign_b, p.b.sign);
      check("exp_b",  out_exp_b,  p.b.exp);
      check("man_b",  out_man_b,  p.b.man);
      check("cls_b",  out_cls_b,  p.b.cls);
      check("invalid", out_invalid, p.inv);
      if (out_ready) void'(q.pop_front());
    end
    if (in_valid && in_ready) begin
      p.a   = model(in_a);
      p.b   = model(in_b);
      p.inv = p.a.cls[5] | p.b.cls[5];
      p.acc = cyc;
      q.push_back(p);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    #1;
    observe();
  endtask

  // Single accepted pair, literal expectations two cycles later
  task automatic directed(input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] ca, input logic [5:0] cb,
                          input logic [8:0] ea, input logic [23:0] ma,
                          input logic sb, input logic inv);
    drive(1'b1, a, b, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    check("d_valid",   out_valid,   1'b1);
    check("d_cls_a",   out_cls_a,   ca);
    check("d_cls_b",   out_cls_b,   cb);
    check("d_exp_a",   out_exp_a,   ea);
    check("d_man_a",   out_man_a,   ma);
    check("d_sign_b",  out_sign_b,  sb);
    check("d_invalid", out_invalid, inv);
  endtask

  initial begin
    logic found;
    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    dp_in_valid = 1'b0; dp_in_a = '0; dp_in_b = '0; dp_out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_exp_a",     out_exp_a, 9'd0);
    check("rst_cls_a",     out_cls_a, 6'd0);
    rst = 1'b1;

    directed(32'h3F800000, 32'h80000000, 6'b000100, 6'b000001, 9'h07F, 24'h800000, 1'b1, 1'b0);
    directed(32'h7F800000, 32'h7FC00000, 6'b001000, 6'b010000, 9'h0FF, 24'h800000, 1'b0, 1'b0);
    directed(32'h7F800001, 32'h00000000, 6'b100000, 6'b000001, 9'h0FF, 24'h800001, 1'b0, 1'b1);
`ifdef FPU_UNPACK_DAZ_EN
    directed(32'h00000001, 32'h00000000, 6'b000001, 6'b000001, 9'h000, 24'h000000, 1'b0, 1'b0);
`else
    directed(32'h00000001, 32'h00000000, 6'b000010, 6'b000001, 9'h001, 24'h000001, 1'b0, 1'b0);
`endif

    // Back-to-back stream
    for (int i = 0; i < 8; i++) drive(1'b1, gen_op(), gen_op(), 1'b1);
    repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b1);
    check("b2b_drained", 64'(q.size()), 64'd0);

    // Stall mid-stream, then release
    for (int i = 0; i < 3; i++) drive(1'b1, gen_op(), gen_op(), 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, gen_op(), gen_op(), 1'b0);
    repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b1);
    check("stall_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset with both stages full
    for (int i = 0; i < 4; i++) drive(1'b1, gen_op(), gen_op(), 1'b0);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_cls_a",     out_cls_a, 6'd0);
    check("arst_man_a",     out_man_a, 24'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b1);
    repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b1);
    check("arst_drained", 64'(q.size()), 64'd0);

    // Random traffic and back-pressure
    repeat (400) drive($urandom_range(0, 3) != 0, gen_op(), gen_op(), $urandom_range(0, 9) < 7);
    repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b1);
    check("rand_drained", 64'(q.size()), 64'd0);

    // Double precision instance
    @(negedge clk);
    dp_in_valid = 1'b1;
    dp_in_a = 64'h3FF0000000000000;
    dp_in_b = 64'h0000000000000000;
    #1;
    check("dp_in_ready", dp_in_ready, 1'b1);
    @(negedge clk);
    dp_in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!found && dp_out_valid) begin
        found = 1'b1;
        check("dp_exp_a", dp_exp_a, 12'h3FF);
        check("dp_cls_a", dp_cls_a, 6'b000100);
        check("dp_man_a", dp_man_a, 53'h10000000000000);
        check("dp_cls_b", dp_cls_b, 6'b000001);
      end
      @(negedge clk);
    end
    check("dp_seen", found, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fp_operand_unpacker
`default_nettype wire
